// File: rtl/logic_gate_pkg.sv
// Shared types and opcode helpers for the logic gate unit and its ALU.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Inverting ops fold with their positive base; the inversion is applied once at the output.
  function automatic op_e base_of(input op_e op);
    op_e b;
    case (op)
      OP_NAND: b = OP_AND;
      OP_NOR:  b = OP_OR;
      OP_XNOR: b = OP_XOR;
      default: b = op;
    endcase
    return b;
  endfunction

  function automatic logic inv_of(input op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise ALU shared by the single-beat and accumulate paths.
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = x & y;
      OP_OR:     result = x | y;
      OP_XOR:    result = x ^ y;
      OP_NAND:   result = ~(x & y);
      OP_NOR:    result = ~(x | y);
      OP_XNOR:   result = ~(x ^ y);
      OP_NOT_A:  result = ~x;
      OP_PASS_A: result = x;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit with single-beat and multi-beat accumulate modes.
// Handshake: a beat transfers on in_valid && in_ready, a result on out_valid && out_ready;
// in_ready = !out_valid || out_ready, so a result drain and a new beat may share an edge.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  input  logic               in_acc,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_parity,
  output logic [COUNT_W-1:0] out_count,
  output state_e             dbg_state
);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] cnt;

  op_e                op_in;
  op_e                alu_op;
  logic [WIDTH-1:0]   alu_x;
  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   res_y;
  logic [COUNT_W-1:0] res_count;
  logic [COUNT_W-1:0] cnt_inc;
  logic               accept;
  logic               start_acc;
  logic               emit;

  assign in_ready  = !out_valid || out_ready;
  assign dbg_state = state;
  assign op_in     = op_e'(in_op);

  always_comb begin
    accept    = in_valid && in_ready;
    start_acc = (state == IDLE) && in_acc && !in_last &&
                (op_in != OP_NOT_A) && (op_in != OP_PASS_A);
    emit      = accept && (((state == IDLE) && !start_acc) ||
                           ((state == ACCUM) && in_last));
    cnt_inc   = (cnt == {COUNT_W{1'b1}}) ? cnt : cnt + COUNT_W'(1);
    if (state == ACCUM) begin
      alu_x     = acc;
      alu_y     = in_a;
      alu_op    = base_of(op_q);
      res_y     = inv_of(op_q) ? ~alu_res : alu_res;
      res_count = cnt_inc;
    end else begin
      alu_x     = in_a;
      alu_y     = in_b;
      alu_op    = start_acc ? base_of(op_in) : op_in;
      res_y     = alu_res;
      res_count = COUNT_W'(1);
    end
  end

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .x      (alu_x),
    .y      (alu_y),
    .op     (alu_op),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_AND;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_zero   <= 1'b1;
      out_parity <= 1'b0;
      out_count  <= '0;
    end else begin
      if (accept) begin
        case (state)
          IDLE: begin
            if (start_acc) begin
              acc   <= alu_res;
              op_q  <= op_in;
              cnt   <= COUNT_W'(1);
              state <= ACCUM;
            end
          end
          ACCUM: begin
            acc <= alu_res;
            cnt <= cnt_inc;
            if (in_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (emit) begin
        out_valid  <= 1'b1;
        out_y      <= res_y;
        out_zero   <= (res_y == '0);
        out_parity <= ^res_y;
        out_count  <= res_count;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench: two instances (COUNT_W=4 and COUNT_W=2) share one stimulus stream.
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_acc;
  logic       in_last;
  logic       out_ready;

  logic       in_ready,   in_ready_s;
  logic       out_valid,  out_valid_s;
  logic [7:0] out_y,      out_y_s;
  logic       out_zero,   out_zero_s;
  logic       out_parity, out_parity_s;
  logic [3:0] out_count;
  logic [1:0] out_count_s;
  state_e     dbg_state,  dbg_state_s;

  int tests = 0;
  int failed = 0;
  bit bp_mode = 1'b0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_s_q[$];
  logic [7:0] burst_a[32];
  logic [7:0] burst_b0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_parity(out_parity), .out_count(out_count), .dbg_state(dbg_state)
  );

  logic_gate_unit #(.WIDTH(8), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_y(out_y_s), .out_zero(out_zero_s),
    .out_parity(out_parity_s), .out_count(out_count_s), .dbg_state(dbg_state_s)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  function automatic logic [7:0] ref_gate(input int kind, input logic [7:0] p, input logic [7:0] q);
    case (kind)
      0:       return p & q;
      1:       return p | q;
      default: return p ^ q;
    endcase
  endfunction

  // Reference: fold the burst with the gate family of the op, invert once for ops 3..5.
  function automatic logic [7:0] ref_result(input int op, input int len);
    logic [7:0] y;
    if (op == 6) return ~burst_a[0];
    if (op == 7) return burst_a[0];
    y = ref_gate(op % 3, burst_a[0], burst_b0);
    for (int i = 1; i < len; i++) y = ref_gate(op % 3, y, burst_a[i]);
    return (op >= 3) ? ~y : y;
  endfunction

  task automatic push_exp(input logic [7:0] y, input int len);
    exp_q.push_back({y, 4'(sat(len, 15)), 2'b00});
    exp_s_q.push_back({y, 4'b0000, 2'(sat(len, 3))});
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic acc, input logic last);
    int waits = 0;
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last; in_valid = 1'b1;
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready) begin
      if (waits > 50) begin
        chk("accept_timeout", 32'(in_ready), 32'(1));
        break;
      end
      @(negedge clk);
      out_ready = (bp_mode && waits < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      waits++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_burst(input int op, input int len, input bit gaps);
    logic acc;
    push_exp(ref_result(op, len), len);
    if (len == 1) begin
      acc = 1'($urandom_range(0, 1));
      send_beat(burst_a[0], burst_b0, 3'(op), acc, acc ? 1'b1 : 1'($urandom_range(0, 1)));
    end else begin
      send_beat(burst_a[0], burst_b0, 3'(op), 1'b1, 1'b0);
      for (int i = 1; i < len; i++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            in_a = 8'($urandom);
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
        end
        send_beat(burst_a[i], 8'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), (i == len - 1));
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    bp_mode = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || exp_s_q.size() != 0) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain", 32'(exp_q.size() + exp_s_q.size()), 32'(0));
    @(negedge clk);
  endtask

  // Monitor: samples between the driver's negedge updates and the next active edge.
  always begin
    logic [13:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(out_y), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("out_y", 32'(out_y), 32'(e[13:6]));
          chk("out_zero", 32'(out_zero), 32'(e[13:6] == 8'h00));
          chk("out_parity", 32'(out_parity), 32'(^e[13:6]));
          chk("out_count", 32'(out_count), 32'(e[5:2]));
        end
      end
      if (out_valid_s && out_ready) begin
        if (exp_s_q.size() == 0) chk("unexpected_out_sat", 32'(out_y_s), 32'hFFFF_FFFF);
        else begin
          e = exp_s_q.pop_front();
          chk("out_y_sat", 32'(out_y_s), 32'(e[13:6]));
          chk("out_count_sat", 32'(out_count_s), 32'(e[1:0]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] single_exp[8];
    single_exp[0] = 8'h42; single_exp[1] = 8'hDB; single_exp[2] = 8'h99; single_exp[3] = 8'hBD;
    single_exp[4] = 8'h24; single_exp[5] = 8'h66; single_exp[6] = 8'h3C; single_exp[7] = 8'hC3;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_y", 32'(out_y), 32'(0));
    chk("rst_out_zero", 32'(out_zero), 32'(1));
    chk("rst_out_parity", 32'(out_parity), 32'(0));
    chk("rst_out_count", 32'(out_count), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Single ops on C3/5A with one-cycle latency.
    for (int op = 0; op < 8; op++) begin
      push_exp(single_exp[op], 1);
      send_beat(8'hC3, 8'h5A, 3'(op), 1'b0, 1'b0);
      #1;
      chk("latency_valid", 32'(out_valid), 32'(1));
      chk("latency_y", 32'(out_y), 32'(single_exp[op]));
      @(negedge clk);
    end
    wait_drain();

    burst_a[0] = 8'h01; burst_a[1] = 8'h02; burst_a[2] = 8'h04; burst_b0 = 8'h10;
    chk("model_or_acc", 32'(ref_result(1, 3)), 32'h17);
    run_burst(1, 3, 1'b0);
    wait_drain();

    burst_a[0] = 8'hFF; burst_a[1] = 8'hFF; burst_a[2] = 8'h0F; burst_b0 = 8'hF0;
    chk("model_nand_acc", 32'(ref_result(3, 3)), 32'hFF);
    run_burst(3, 3, 1'b0);
    wait_drain();

    for (int i = 0; i < 6; i++) burst_a[i] = 8'($urandom);
    burst_b0 = 8'($urandom);
    run_burst(2, 6, 1'b1);
    wait_drain();

    // Back-pressure: result held for 5 cycles, then drained alongside a new beat.
    out_ready = 1'b0;
    push_exp(8'hDB, 1);
    send_beat(8'hC3, 8'h5A, 3'd1, 1'b0, 1'b0);
    repeat (5) begin
      #2;
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      chk("stall_valid", 32'(out_valid), 32'(1));
      chk("stall_y", 32'(out_y), 32'hDB);
      chk("stall_count", 32'(out_count), 32'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    push_exp(8'hFF, 1);
    send_beat(8'h0F, 8'hF0, 3'd2, 1'b0, 1'b0);
    #1;
    chk("no_bubble_valid", 32'(out_valid), 32'(1));
    chk("no_bubble_y", 32'(out_y), 32'hFF);
    @(negedge clk);
    wait_drain();

    // Reset in the middle of an accumulation discards it.
    send_beat(8'h01, 8'h10, 3'd1, 1'b1, 1'b0);
    send_beat(8'h02, 8'h00, 3'd1, 1'b0, 1'b0);
    chk("pre_rst_state", 32'(dbg_state), 32'(ACCUM));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_valid_sat", 32'(out_valid_s), 32'(0));
    chk("mid_rst_state_sat", 32'(dbg_state_s), 32'(IDLE));
    @(negedge clk);
    push_exp(8'hFF, 1);
    send_beat(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0);
    wait_drain();

    // Randomized traffic with back-pressure and input gaps.
    for (int t = 0; t < 150; t++) begin
      int op;
      int len;
      bp_mode = 1'b1;
      op = $urandom_range(0, 7);
      len = (op >= 6 || $urandom_range(0, 1) == 0) ? 1 : $urandom_range(2, 20);
      for (int i = 0; i < len; i++) burst_a[i] = 8'($urandom);
      burst_b0 = 8'($urandom);
      run_burst(op, len, 1'b1);
    end
    wait_drain();

    chk("queue_empty", 32'(exp_q.size() + exp_s_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
